// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, registered results held until the next completion.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ZERO = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] quo_q,       quo_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    // The partial remainder stays below the divisor between iterations, so only
    // the shifted value needs the extra bit for the trial subtraction.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor_q};

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d     = dividend;
                    rem_d     = '0;
                    divisor_d = divisor;
                    cnt_d     = CW'(WIDTH);
                    state_d   = (divisor != '0) ? RUN : ZERO;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                end
            end
            // The work quotient register still holds the captured dividend here.
            ZERO: begin
                quotient_d  = '1;
                remainder_d = quo_q;
                dbz_d       = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed vector
// table, protocol and reset sequences, then random operand pairs.
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks;
    int errors;
    int accepted;
    int doneCount;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[8];

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) doneCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Issues one operation and follows it to its done pulse. The edge count
    // includes the accepting edge; disturb re-asserts start with new operands mid-run.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit disturb,
                                 output logic [7:0] q, output logic [7:0] r, output logic z,
                                 output int edges, output int busyCycles);
        int n;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        accepted++;
        n = 0;
        busyCycles = 0;
        while (n < 40 && !done) begin
            if (busy) busyCycles++;
            if (disturb && n == 3) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            if (disturb && n == 4) begin
                start    = 1'b0;
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        if (done) begin
            edges = n + 1;
            @(posedge clk);
            #1;
            checkOutput("donePulseLen", {31'd0, done}, 32'd0);
        end else begin
            edges = -1;
        end
    endtask

    initial begin
        logic [7:0] q, r;
        logic       z;
        int         edges, busyCycles;
        bit         sawDone;

        checks    = 0;
        errors    = 0;
        accepted  = 0;
        doneCount = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;

        vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   z: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
        vecs[2] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
        vecs[3] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   z: 1'b0};
        vecs[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,   z: 1'b0};
        vecs[5] = '{a: 8'd200, b: 8'd0,   q: 8'd255, r: 8'd200, z: 1'b1};
        vecs[6] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   z: 1'b0};
        vecs[7] = '{a: 8'd1,   b: 8'd1,   q: 8'd1,   r: 8'd0,   z: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetQuot", {24'd0, quotient}, 32'd0);
        checkOutput("resetRem",  {24'd0, remainder}, 32'd0);
        checkOutput("resetDbz",  {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b0, q, r, z, edges, busyCycles);
            checkOutput($sformatf("vec%0d_quot", i), {24'd0, q}, {24'd0, vecs[i].q});
            checkOutput($sformatf("vec%0d_rem", i),  {24'd0, r}, {24'd0, vecs[i].r});
            checkOutput($sformatf("vec%0d_dbz", i),  {31'd0, z}, {31'd0, vecs[i].z});
            checkOutput($sformatf("vec%0d_edges", i), 32'(edges), (vecs[i].b == 8'd0) ? 32'd2 : 32'd9);
            checkOutput($sformatf("vec%0d_busy", i), 32'(busyCycles), (vecs[i].b == 8'd0) ? 32'd0 : 32'd8);
        end

        // Start re-issued and operands scrambled mid-run must not disturb the result.
        applyStimulus(8'd100, 8'd7, 1'b1, q, r, z, edges, busyCycles);
        checkOutput("ignoreStartQuot", {24'd0, q}, 32'd14);
        checkOutput("ignoreStartRem",  {24'd0, r}, 32'd2);
        checkOutput("ignoreStartEdges", 32'(edges), 32'd9);

        // Results must be held stable while idle.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("holdQuot", {24'd0, quotient}, 32'd14);
        checkOutput("holdRem",  {24'd0, remainder}, 32'd2);

        // Asynchronous reset in the fourth RUN cycle aborts the operation.
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortQuot", {24'd0, quotient}, 32'd0);
        checkOutput("abortRem",  {24'd0, remainder}, 32'd0);
        checkOutput("abortDbz",  {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        sawDone = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("noDoneAfterAbort", {31'd0, sawDone}, 32'd0);
        applyStimulus(8'd100, 8'd7, 1'b0, q, r, z, edges, busyCycles);
        checkOutput("afterResetQuot", {24'd0, q}, 32'd14);
        checkOutput("afterResetRem",  {24'd0, r}, 32'd2);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom_range(1, 255));
            applyStimulus(a, b, 1'b0, q, r, z, edges, busyCycles);
            checkOutput($sformatf("rnd%0d_%0d/%0d_inv", i, a, b), 32'(q) * 32'(b) + 32'(r), 32'(a));
            checkOutput($sformatf("rnd%0d_%0d/%0d_remLtDiv", i, a, b), {31'd0, (r < b)}, 32'd1);
            checkOutput($sformatf("rnd%0d_edges", i), 32'(edges), 32'd9);
        end

        checkOutput("doneCount", 32'(doneCount), 32'(accepted));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
